// File: rtl/prob_burst_err_gen_if.sv
// Probability-table load bus and error-sample outputs of prob_burst_err_gen.
// Handshake: there is no valid/ready pair on the load side. A write is accepted
// on any rising edge where en=0 and probability_idx < N_ENTRIES. On the output
// side, err_out is meaningful only in cycles where err_valid=1. There is no
// backpressure, so the consumer must take every valid sample.
interface prob_burst_err_gen_if #(
  parameter int PROB_W = 32
);
  logic              en;
  logic [31:0]       probability_idx;
  logic [PROB_W-1:0] probability_in;
  logic              table_ready;
  logic              err_valid;
  logic              err_out;
  logic [6:0]        burst_state;
  logic [63:0]       total_samples;
  logic [63:0]       total_errors;

  // Table loader / sample consumer side
  modport master (
    output en, probability_idx, probability_in,
    input  table_ready, err_valid, err_out, burst_state, total_samples, total_errors
  );

  // Error generator side
  modport slave (
    input  en, probability_idx, probability_in,
    output table_ready, err_valid, err_out, burst_state, total_samples, total_errors
  );
endinterface

// File: rtl/prob_burst_err_gen.sv
// Markov burst-error generator.
// An N-entry probability table is indexed by the current burst length, which
// is the number of consecutive errors, saturating at N_ENTRIES-1. Each enabled
// cycle, the selected entry is compared with a fresh 32-bit Galois LFSR draw.
// burst_state is the only piece of sequencing state, and it is exported
// directly on the bus.
module prob_burst_err_gen #(
  parameter int          N_ENTRIES = 84,
  parameter int          PROB_W    = 32,
  parameter logic [31:0] SEED      = 32'h1
) (
  input logic                clk,
  input logic                rstn,
  prob_burst_err_gen_if.slave bus
);

  localparam int                IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [6:0]        MAX_STATE = 7'(N_ENTRIES - 1);
  localparam logic [PROB_W-1:0] TAPS      = PROB_W'(32'h80200003);
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [PROB_W-1:0] SEED_EFF  = (SEED == 32'h0) ? PROB_W'(1) : PROB_W'(SEED);

  logic [PROB_W-1:0]    tbl [N_ENTRIES];
  logic [N_ENTRIES-1:0] loaded;
  logic                 ready_q;
  logic [PROB_W-1:0]    lfsr_q;
  logic [PROB_W-1:0]    lfsr_next;
  logic [PROB_W-1:0]    cur_prob;
  logic [6:0]           state_q;
  logic                 err_valid_q;
  logic                 err_out_q;
  logic [63:0]          samples_q;
  logic [63:0]          errors_q;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic                 step;
  logic                 hit;

  // Writes are only honoured while stopped, so the table never changes under a running generator.
  assign wr_en  = !bus.en && (bus.probability_idx < 32'(N_ENTRIES));
  assign wr_idx = bus.probability_idx[IDX_W-1:0];
  assign step   = bus.en && ready_q;

  // Next LFSR value, next table entry and the hit decision, all combinational so there is no read bubble
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[PROB_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    cur_prob  = tbl[state_q[IDX_W-1:0]];
    hit       = (lfsr_next <= cur_prob);
  end

  // Probability table and loaded mask
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
      loaded <= '0;
    end else if (wr_en) begin
      tbl[wr_idx]    <= bus.probability_in;
      loaded[wr_idx] <= 1'b1;
    end
  end

  // table_ready is a registered copy of "every entry loaded", so it is sticky until reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_q <= 1'b0;
    else       ready_q <= ready_q | (&loaded);
  end

  // LFSR, burst state and the registered error sample, all advancing only on step cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q      <= SEED_EFF;
      state_q     <= '0;
      err_valid_q <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      err_valid_q <= step;
      if (step) begin
        lfsr_q    <= lfsr_next;
        err_out_q <= hit;
        if (!hit)                    state_q <= '0;
        else if (state_q < MAX_STATE) state_q <= state_q + 7'd1;
      end
    end
  end

  // Sample and error counters, which wrap modulo 2^64
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samples_q <= '0;
      errors_q  <= '0;
    end else if (step) begin
      samples_q <= samples_q + 64'd1;
      errors_q  <= errors_q + {63'd0, hit};
    end
  end

  assign bus.table_ready   = ready_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.err_out       = err_out_q;
  assign bus.burst_state   = state_q;
  assign bus.total_samples = samples_q;
  assign bus.total_errors  = errors_q;

endmodule

// File: tb/tb_prob_burst_err_gen.sv
// Testbench for prob_burst_err_gen. A behavioural model kept alongside the DUT
// predicts every output on every cycle, and the error bit stream is also
// matched through an expected queue.
module tb_prob_burst_err_gen;

  localparam int          N    = 84;
  localparam logic [31:0] SEED = 32'h1;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  prob_burst_err_gen_if #(.PROB_W(32)) bus ();

  prob_burst_err_gen #(
    .N_ENTRIES(N),
    .PROB_W(32),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [31:0]     m_tbl [N];
  bit              m_loaded [N];
  bit              m_ready;
  logic [31:0]     m_lfsr;
  int              m_state;
  bit              m_err;
  bit              m_valid;
  longint unsigned m_samples;
  longint unsigned m_errors;
  logic [0:0]      exp_q [$];
  logic [31:0]     saved_tbl [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // LFSR draw: x^32+x^22+x^2+x+1, Galois form, shifting right
  function automatic logic [31:0] galois(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tbl[i]    = '0;
      m_loaded[i] = 1'b0;
    end
    m_ready   = 1'b0;
    m_lfsr    = (SEED == 32'h0) ? 32'h1 : SEED;
    m_state   = 0;
    m_err     = 1'b0;
    m_valid   = 1'b0;
    m_samples = 0;
    m_errors  = 0;
    exp_q.delete();
  endtask

  // one clock: advance the model from pre-edge inputs, then compare every output
  task automatic tick();
    bit          all_loaded;
    bit          hit;
    logic [31:0] rnd;
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else begin
      all_loaded = 1'b1;
      for (int i = 0; i < N; i++) if (!m_loaded[i]) all_loaded = 1'b0;
      if (bus.en && m_ready) begin
        rnd       = galois(m_lfsr);
        m_lfsr    = rnd;
        hit       = (rnd <= m_tbl[m_state]);
        m_err     = hit;
        m_valid   = 1'b1;
        m_state   = hit ? ((m_state + 1 > N - 1) ? N - 1 : m_state + 1) : 0;
        m_samples = m_samples + 1;
        if (hit) m_errors = m_errors + 1;
        exp_q.push_back(hit);
      end else begin
        m_valid = 1'b0;
      end
      if (!bus.en && bus.probability_idx < N) begin
        m_tbl[bus.probability_idx]    = bus.probability_in;
        m_loaded[bus.probability_idx] = 1'b1;
      end
      m_ready = m_ready || all_loaded;
    end
    check("table_ready", 64'(bus.table_ready), 64'(m_ready));
    check("err_valid", 64'(bus.err_valid), 64'(m_valid));
    check("err_out", 64'(bus.err_out), 64'(m_err));
    check("burst_state", 64'(bus.burst_state), 64'(m_state));
    check("total_samples", bus.total_samples, m_samples);
    check("total_errors", bus.total_errors, m_errors);
    if (bus.err_valid) begin
      if (exp_q.size() == 0) check("err_stream_extra", 64'd1, 64'd0);
      else                   check("err_stream", 64'(bus.err_out), 64'(exp_q.pop_front()));
    end
  endtask

  // driver tasks
  task automatic write(input logic [31:0] idx, input logic [31:0] data);
    bus.en              = 1'b0;
    bus.probability_idx = idx;
    bus.probability_in  = data;
    tick();
    bus.probability_idx = ONES;
  endtask

  task automatic run(input int n);
    bus.en = 1'b1;
    repeat (n) tick();
    bus.en = 1'b0;
  endtask

  // reset is applied between edges so its asynchronous effect can be observed
  task automatic do_reset();
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    bus.en = 1'b0;
    rstn   = 1'b0;
    #1;
    model_reset();
    check("rst_table_ready", 64'(bus.table_ready), 64'd0);
    check("rst_err_valid", 64'(bus.err_valid), 64'd0);
    check("rst_err_out", 64'(bus.err_out), 64'd0);
    check("rst_burst_state", 64'(bus.burst_state), 64'd0);
    check("rst_total_samples", bus.total_samples, 64'd0);
    check("rst_total_errors", bus.total_errors, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic load_const(input logic [31:0] first, input logic [31:0] rest);
    write(32'd0, first);
    for (int i = 1; i < N; i++) write(32'(i), rest);
  endtask

  initial begin
    bus.en              = 1'b0;
    bus.probability_idx = ONES;
    bus.probability_in  = '0;
    model_reset();
    tick();
    do_reset();

    // all-zero table: never an error
    load_const(32'd0, 32'd0);
    check("ready_after_load", 64'(bus.table_ready), 64'd0);
    bus.en = 1'b1;
    tick();
    check("ready_one_later", 64'(bus.table_ready), 64'd1);
    check("no_sample_yet", 64'(bus.err_valid), 64'd0);
    tick();
    check("first_sample", 64'(bus.err_valid), 64'd1);
    repeat (999) tick();
    bus.en = 1'b0;
    check("zero_samples", bus.total_samples, 64'd1000);
    check("zero_errors", bus.total_errors, 64'd0);
    tick();

    // all-ones table: an error every step and the burst state saturates
    do_reset();
    load_const(ONES, ONES);
    run(84);
    check("ones_state_83", 64'(bus.burst_state), 64'd83);
    run(117);
    check("ones_state_hold", 64'(bus.burst_state), 64'd83);
    check("ones_samples", bus.total_samples, 64'd200);
    check("ones_errors", bus.total_errors, 64'd200);
    tick();

    // entry 0 always, all others never: alternating 1,0,1,0
    do_reset();
    load_const(ONES, 32'd0);
    run(101);
    check("alt_errors", bus.total_errors, 64'd50);
    check("alt_samples", bus.total_samples, 64'd100);
    // writes while running and out-of-range writes must not disturb the table
    bus.en              = 1'b1;
    bus.probability_idx = 32'd0;
    bus.probability_in  = 32'd0;
    repeat (20) tick();
    bus.probability_idx = 32'd1;
    bus.probability_in  = ONES;
    repeat (20) tick();
    bus.en = 1'b0;
    write(32'd84, 32'd0);
    write(ONES, 32'd0);
    write(32'd200, 32'd0);
    run(40);
    check("alt_errors_after", bus.total_errors, 64'd90);
    tick();

    // partial load: generator stays idle until the last entry arrives
    do_reset();
    for (int i = 0; i < N - 1; i++) write(32'(i), $urandom());
    run(20);
    check("partial_not_ready", 64'(bus.table_ready), 64'd0);
    check("partial_no_samples", bus.total_samples, 64'd0);
    write(32'd83, $urandom());
    check("last_write_ready_lag", 64'(bus.table_ready), 64'd0);
    tick();
    check("last_write_ready", 64'(bus.table_ready), 64'd1);
    // rewriting an entry keeps ready high
    write(32'd5, 32'd0);
    check("rewrite_keeps_ready", 64'(bus.table_ready), 64'd1);

    // random table, random enable with a 10-cycle pause, then reset mid-run
    do_reset();
    for (int i = 0; i < N; i++) begin
      saved_tbl[i] = (i % 3 == 0) ? $urandom() : ONES - 32'($urandom_range(0, 32'h0FFF_FFFF));
      write(32'(i), saved_tbl[i]);
    end
    for (int c = 0; c < 300; c++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.en = 1'b0;
    repeat (10) tick();
    run(150);
    bus.en = 1'b1;
    repeat (37) tick();
    do_reset();
    for (int i = 0; i < N; i++) write(32'(i), saved_tbl[i]);
    run(200);
    check("rerun_samples", bus.total_samples, 64'd199);
    tick();
    check("stream_drained_end", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prob_burst_err_gen.md
Name: prob_burst_err_gen

Overview:
- Receiving end of the probability-table load interface used by the FEC simulation systems.
- Captures indexed 32-bit probability writes into an N-entry table.
- Once fully loaded and enabled, generates one channel-error bit per cycle from a Markov burst model. The current burst length selects the table entry, which is compared against a 32-bit LFSR draw.
- Feeds the error-injection point ahead of the precoder/decoder path and keeps its own sample and error counters.

Parameters:
N_ENTRIES, 84, number of table entries / burst states (2..128)
PROB_W, 32, probability word width; must equal LFSR width
SEED, 32'h1, LFSR reset value; 0 is replaced by 1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  run enable; also freezes the table while high
probability_idx  in  32  write index; 32'hFFFFFFFF or any value >= N_ENTRIES means no write
probability_in  in  PROB_W  write data; unsigned threshold, 0 = never, all-ones = always
table_ready  out  1  all N_ENTRIES written since reset
err_valid  out  1  err_out carries a sample this cycle
err_out  out  1  generated error bit
burst_state  out  7  current burst state (consecutive errors, saturating)
total_samples  out  64  count of err_valid cycles
total_errors  out  64  count of err_valid cycles with err_out=1

Behaviour:
- Reset (async, rstn=0):
  - Clears table contents, loaded mask, burst_state, err_valid, err_out and both counters.
  - Sets table_ready to 0 and loads the LFSR with SEED (or 1 if SEED=0).
  - Deassertion is sampled synchronously.
- Write:
  - On a rising edge with en=0 and probability_idx < N_ENTRIES: table[idx] <= probability_in and loaded[idx] <= 1.
  - Out-of-range indices are ignored.
  - Writes while en=1 are ignored.
  - Rewriting an entry is allowed and does not clear ready.
- table_ready: registered AND of the loaded mask. It rises on the cycle after the last missing entry's write edge and stays high until reset.
- Step condition: step = en & table_ready. Each step cycle:
  - LFSR advances once: 32-bit Galois, right shift, taps mask 32'h80200003 (x^32+x^22+x^2+x+1).
  - rnd is the post-advance LFSR value.
  - hit = (rnd <= table[burst_state]), unsigned.
  - Registered outputs, latency 1 cycle: err_out <= hit, err_valid <= 1.
  - hit=1: burst_state <= min(burst_state+1, N_ENTRIES-1), saturating at N_ENTRIES-1.
  - hit=0: burst_state <= 0.
  - total_samples += 1, and total_errors += hit, in the same edge.
- Non-step cycles:
  - err_valid <= 0; err_out, burst_state, LFSR and counters hold.
  - Deasserting en mid-run pauses cleanly; re-asserting resumes with the same LFSR and state.
- LFSR never reaches 0, so rnd >= 1:
  - Probability 0 produces no errors.
  - All-ones produces an error every step.
- Counters: 64-bit, wrap silently modulo 2^64. No saturation.
- Table read is combinational from registers, so there is no read bubble. A distributed-RAM implementation must keep the 1-cycle output latency.
- Simultaneous write and step is impossible, because writes require en=0.
- Reset mid-run: immediate return to the reset state. The table must be reloaded before table_ready rises again.

Test Plan:
- Load all 84 entries with 0, then en=1 for 1000 cycles: first err_valid 1 cycle after en with table_ready=1; total_samples=1000, total_errors=0, burst_state=0 throughout.
- Load all entries with 32'hFFFFFFFF, en=1 for 200 cycles: err_out=1 every sample; burst_state reaches 83 after 83 steps and holds; total_errors=total_samples=200.
- Entry0=32'hFFFFFFFF, all others 0: err_out sequence 1,0,1,0,…; burst_state alternates 0/1; after 100 steps total_errors=50.
- Load only indices 0..82, then en=1: table_ready=0, err_valid never high, counters stay 0. Write index 83: table_ready rises 1 cycle later.
- Out-of-range and frozen writes:
  - With the table loaded, write idx=84 and idx=32'hFFFFFFFF: table unchanged.
  - With en=1, write idx 0: ignored, verified via the all-ones/zero pattern.
- Mid-run checks:
  - Pause: drop en for 10 cycles; err_valid=0 and counters hold, and the resumed sequence matches an uninterrupted reference model.
  - Reset: assert rstn=0 mid-run; all outputs go to 0 asynchronously, and after reload the sequence restarts from SEED.
